// File: rtl/rr_encoder4to2_if.sv
// Request/result bundle for the 4-request arbiter-encoder.
// The master side is the encoder, the slave side is the requester/consumer.
interface rr_encoder4to2_if;
  logic [3:0] req;
  logic [1:0] out;
  logic [3:0] grant;
  logic       valid;
  logic       ready;
  logic       multi;

  modport master (
    input  req,
    input  ready,
    output out,
    output grant,
    output valid,
    output multi
  );

  modport slave (
    output req,
    output ready,
    input  out,
    input  grant,
    input  valid,
    input  multi
  );
endinterface

// File: rtl/rr_encoder4to2.sv
// Registered 4-request round-robin/fixed-priority arbiter with one-hot grant,
// binary index and multi-request flag held behind a valid/ready handshake.
module rr_encoder4to2 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_encoder4to2_if.master bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0] r_state;
  logic [1:0] r_ptr;
  logic [1:0] r_out;
  logic [3:0] r_grant;
  logic       r_multi;

  logic       w_hs;
  logic       w_any;
  logic       w_multi;
  logic [1:0] w_ptr_nxt;
  logic [1:0] w_ptr_use;
  logic [1:0] w_win;

  assign w_hs      = (r_state == S_HOLD) && bus.ready;
  assign w_ptr_nxt = RR_EN ? r_out + 2'd1 : 2'd0;
  // a back-to-back capture must search from the freshly advanced pointer
  assign w_ptr_use = w_hs ? w_ptr_nxt : r_ptr;
  assign w_any     = |bus.req;
  assign w_multi   = |(bus.req & (bus.req - 4'd1));

  always_comb begin
    w_win = w_ptr_use;
    for (int i = 3; i >= 0; i--) begin
      if (bus.req[w_ptr_use + 2'(i)]) begin
        w_win = w_ptr_use + 2'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= 2'd0;
      r_out   <= 2'd0;
      r_grant <= 4'd0;
      r_multi <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_any) begin
        r_state <= S_HOLD;
        r_out   <= w_win;
        r_grant <= 4'b0001 << w_win;
        r_multi <= w_multi;
      end
    end else if (bus.ready) begin
      r_ptr <= w_ptr_nxt;
      if (w_any) begin
        r_out   <= w_win;
        r_grant <= 4'b0001 << w_win;
        r_multi <= w_multi;
      end else begin
        r_state <= S_IDLE;
        r_out   <= 2'd0;
        r_grant <= 4'd0;
        r_multi <= 1'b0;
      end
    end
  end

  assign bus.out   = r_out;
  assign bus.grant = r_grant;
  assign bus.multi = r_multi;
  assign bus.valid = (r_state == S_HOLD);

endmodule

// File: tb/tb_rr_encoder4to2.sv
// Scoreboard bench for rr_encoder4to2: round-robin and fixed-priority
// instances, directed vectors, async reset and backpressure.
module tb_rr_encoder4to2;

  typedef struct packed {
    logic [1:0] o;
    logic [3:0] g;
    logic       m;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;

  exp_t q0[$];
  exp_t q1[$];

  rr_encoder4to2_if b0 ();
  rr_encoder4to2_if b1 ();

  rr_encoder4to2 #(.RR_EN(1'b1)) u_rr (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b0)
  );

  rr_encoder4to2 #(.RR_EN(1'b0)) u_fx (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] want);
    n_run++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic cmp_res(input string nm, input exp_t e,
                         input logic [1:0] o, input logic [3:0] g,
                         input logic m);
    chk({nm, ".out"}, {6'd0, o}, {6'd0, e.o});
    chk({nm, ".grant"}, {4'd0, g}, {4'd0, e.g});
    chk({nm, ".multi"}, {7'd0, m}, {7'd0, e.m});
    chk({nm, ".onehot"}, {4'd0, g}, {4'd0, 4'b0001 << o});
  endtask

  // a result is consumed at the edge after a cycle with valid && ready
  always @(negedge clk) begin
    if (rst_n && b0.valid && b0.ready) begin
      if (q0.size() == 0) begin
        chk("rr.unexpected", 8'd1, 8'd0);
      end else begin
        cmp_res("rr", q0.pop_front(), b0.out, b0.grant, b0.multi);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b1.valid && b1.ready) begin
      if (q1.size() == 0) begin
        chk("fx.unexpected", 8'd1, 8'd0);
      end else begin
        cmp_res("fx", q1.pop_front(), b1.out, b1.grant, b1.multi);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic [3:0] r, input logic rd);
    b0.req   = r;
    b0.ready = rd;
  endtask

  task automatic push0(input logic [1:0] o, input logic [3:0] g,
                       input logic m);
    exp_t e;
    e.o = o;
    e.g = g;
    e.m = m;
    q0.push_back(e);
  endtask

  task automatic push1(input logic [1:0] o, input logic [3:0] g,
                       input logic m);
    exp_t e;
    e.o = o;
    e.g = g;
    e.m = m;
    q1.push_back(e);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, ".valid"}, {7'd0, b0.valid}, 8'd0);
    chk({nm, ".out"}, {6'd0, b0.out}, 8'd0);
    chk({nm, ".grant"}, {4'd0, b0.grant}, 8'd0);
    chk({nm, ".multi"}, {7'd0, b0.multi}, 8'd0);
  endtask

  initial begin
    drv0(4'b0000, 1'b0);
    b1.req   = 4'b0000;
    b1.ready = 1'b0;
    #12;
    chk_idle("reset");
    rst_n = 1'b1;
    drv0(4'b0000, 1'b1);
    step();
    step();
    chk_idle("idle_ready");

    // single-hot sweep, back-to-back with ready high
    drv0(4'b0001, 1'b1);
    push0(2'd0, 4'b0001, 1'b0);
    step();
    chk("cap_latency.valid", {7'd0, b0.valid}, 8'd1);
    drv0(4'b0010, 1'b1);
    push0(2'd1, 4'b0010, 1'b0);
    step();
    drv0(4'b0100, 1'b1);
    push0(2'd2, 4'b0100, 1'b0);
    step();
    drv0(4'b1000, 1'b1);
    push0(2'd3, 4'b1000, 1'b0);
    step();
    drv0(4'b0000, 1'b1);
    step();
    chk_idle("sweep_drop");

    // all requesting: round-robin rotation including wrap 11 -> 00
    drv0(4'b1111, 1'b1);
    push0(2'd0, 4'b0001, 1'b1);
    push0(2'd1, 4'b0010, 1'b1);
    push0(2'd2, 4'b0100, 1'b1);
    push0(2'd3, 4'b1000, 1'b1);
    push0(2'd0, 4'b0001, 1'b1);
    repeat (5) step();
    drv0(4'b0000, 1'b1);
    step();
    chk_idle("rr_drop");

    // backpressure: ptr is now 1, so 0100 wins as index 2
    drv0(4'b0100, 1'b0);
    push0(2'd2, 4'b0100, 1'b0);
    step();
    drv0(4'b1000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp.out", {6'd0, b0.out}, 8'd2);
      chk("bp.grant", {4'd0, b0.grant}, 8'h04);
    end
    drv0(4'b1000, 1'b1);
    push0(2'd3, 4'b1000, 1'b0);
    step();
    drv0(4'b0000, 1'b0);
    step();
    chk("hold.valid", {7'd0, b0.valid}, 8'd1);

    // async reset between edges discards the held result
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    void'(q0.pop_front());
    step();
    rst_n = 1'b1;
    step();
    step();
    chk_idle("post_rst");

    // fixed priority: 0110 always resolves to bit 1
    b1.req   = 4'b0110;
    b1.ready = 1'b1;
    repeat (4) push1(2'd1, 4'b0010, 1'b1);
    repeat (4) step();
    b1.req = 4'b0000;
    step();
    chk("fx_drop.valid", {7'd0, b1.valid}, 8'd0);

    step();
    chk("rr.q_empty", 8'(q0.size()), 8'd0);
    chk("fx.q_empty", 8'(q1.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
